// File: rtl/div_32b_if.sv
// Handshake and operand/result bundle for the 32-bit signed divider.
// The master drives operands and the start strobe; the slave returns results.
interface div_32b_if;
  logic [31:0] x;
  logic [31:0] y;
  logic        in_valid;
  logic [31:0] q;
  logic [31:0] r;
  logic        out_valid;
  logic        div_zero;

  modport master (output x, y, in_valid, input q, r, out_valid, div_zero);
  modport slave  (input x, y, in_valid, output q, r, out_valid, div_zero);
endinterface

// File: rtl/div_32b.sv
// Iterative 32-bit signed divider: restoring division on magnitudes over 32
// cycles, then a one-cycle sign fix-up. A zero divisor skips straight to fix-up.
module div_32b (
  input  logic      clk,
  input  logic      rst_n,
  div_32b_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic        r_sign_x;
  logic        r_neg_q;
  logic        r_zero;
  logic [31:0] r_x;
  logic [31:0] r_abs_y;
  logic [64:0] r_work;
  logic [31:0] r_q;
  logic [31:0] r_r;
  logic        r_div_zero;

  logic [31:0] w_abs_x;
  logic [31:0] w_abs_y;
  logic [64:0] w_shift;
  logic [32:0] w_trial;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_out_valid;

  // Negating 0x80000000 wraps back to itself, which is the correct magnitude.
  assign w_abs_x = bus.x[31] ? (32'd0 - bus.x) : bus.x;
  assign w_abs_y = bus.y[31] ? (32'd0 - bus.y) : bus.y;
  assign w_shift = {r_work[63:0], 1'b0};
  assign w_trial = w_shift[64:32] - {1'b0, r_abs_y};
  assign w_quo   = r_work[31:0];
  assign w_rem   = r_work[63:32];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_out_valid = 1'b0;
    if (r_state == S_IDLE) w_out_valid = 1'b1;
    if (bus.in_valid) begin
      w_state_nxt = (bus.y == 32'd0) ? S_FIX : S_CALC;
    end else begin
      case (r_state)
        S_CALC:  if (r_cnt == 6'd1) w_state_nxt = S_FIX;
        S_FIX:   w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 6'd0;
      r_sign_x   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_zero     <= 1'b0;
      r_x        <= 32'd0;
      r_abs_y    <= 32'd0;
      r_work     <= 65'd0;
      r_q        <= 32'd0;
      r_r        <= 32'd0;
      r_div_zero <= 1'b0;
    end else if (bus.in_valid) begin
      // A load always wins, even over a fix-up landing on the same edge.
      r_cnt      <= 6'd32;
      r_sign_x   <= bus.x[31];
      r_neg_q    <= bus.x[31] ^ bus.y[31];
      r_zero     <= (bus.y == 32'd0);
      r_x        <= bus.x;
      r_abs_y    <= w_abs_y;
      r_work     <= {33'd0, w_abs_x};
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_CALC: begin
          if (!w_trial[32]) r_work <= {w_trial, w_shift[31:1], 1'b1};
          else              r_work <= w_shift;
          r_cnt <= r_cnt - 6'd1;
        end
        S_FIX: begin
          if (r_zero) begin
            r_q        <= 32'hFFFF_FFFF;
            r_r        <= r_x;
            r_div_zero <= 1'b1;
          end else begin
            r_q <= r_neg_q  ? (32'd0 - w_quo) : w_quo;
            r_r <= r_sign_x ? (32'd0 - w_rem) : w_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.q         = r_q;
  assign bus.r         = r_r;
  assign bus.div_zero  = r_div_zero;
  assign bus.out_valid = w_out_valid;

endmodule

// File: tb/tb_div_32b.sv
// Self-checking bench for div_32b: vector table plus hand-written sequences
// for restart, load/fix collision, held start and mid-operation reset.
module tb_div_32b;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  div_32b_if bus ();

  div_32b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          busy;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    else             n_pass++;
  endtask

  function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r, input logic dz);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.busy = dz ? 1 : 33;
    return e;
  endfunction

  // Called at a negedge: holds in_valid for one rising edge, then scrambles
  // the operand inputs to prove the DUT works from latched copies.
  task automatic start(input logic [31:0] x, input logic [31:0] y, input bit push, input exp_t e);
    bus.x        = x;
    bus.y        = y;
    bus.in_valid = 1'b1;
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x        = $urandom;
    bus.y        = $urandom;
  endtask

  // Counts busy cycles (sampled on negedges) up to a bound, then pops and compares.
  task automatic wait_done(input string name);
    int   busy;
    exp_t e;
    busy = 0;
    while (!bus.out_valid && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s: result seen, scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check({name, "_busy"}, busy, e.busy);
      check({name, "_q"}, bus.q, e.q);
      check({name, "_r"}, bus.r, e.r);
      check({name, "_dz"}, {31'd0, bus.div_zero}, {31'd0, e.dz});
    end
  endtask

  initial begin
    exp_t none;
    none = mk(32'd0, 32'd0, 1'b0);

    vecs[0] = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[1] = '{-32'sd100,     32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    vecs[2] = '{32'd100,       -32'sd7,       32'hFFFF_FFF2, 32'd2,         1'b0};
    vecs[3] = '{-32'sd100,     -32'sd7,       32'd14,        32'hFFFF_FFFE, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0};
    vecs[5] = '{32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         1'b0};
    vecs[6] = '{32'd5,         32'h8000_0000, 32'd0,         32'd5,         1'b0};
    vecs[7] = '{32'd1234,      32'd0,         32'hFFFF_FFFF, 32'd1234,      1'b1};
    vecs[8] = '{32'd9,         32'd3,         32'd3,         32'd0,         1'b0};

    bus.x = 32'd0; bus.y = 32'd0; bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("rst_q", bus.q, 32'd0);
    check("rst_r", bus.r, 32'd0);
    check("rst_dz", {31'd0, bus.div_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, back to back: each load lands in the first idle cycle.
    for (int i = 0; i < 9; i++) begin
      start(vecs[i].x, vecs[i].y, 1'b1, mk(vecs[i].q, vecs[i].r, vecs[i].dz));
      wait_done($sformatf("vec%0d", i));
    end

    // Load on the same edge as fix-up: pending 100/7 discarded, outputs hold 9/3.
    start(32'd100, 32'd7, 1'b0, none);
    repeat (32) @(negedge clk);
    start(32'd20, 32'd3, 1'b1, mk(32'd6, 32'd2, 1'b0));
    check("collide_hold_q", bus.q, 32'd3);
    check("collide_busy", {31'd0, bus.out_valid}, 32'd0);
    wait_done("collide");

    // Restart mid-flight: only the second operation's result may appear.
    start(32'd100, 32'd7, 1'b0, none);
    repeat (9) @(negedge clk);
    check("restart_still_busy", {31'd0, bus.out_valid}, 32'd0);
    start(32'd50, 32'd6, 1'b1, mk(32'd8, 32'd2, 1'b0));
    wait_done("restart");

    // Held in_valid: the last edge's operands win and timing restarts there.
    bus.in_valid = 1'b1;
    bus.x = 32'd1000; bus.y = 32'd3;
    @(negedge clk);
    bus.x = 32'd500;  bus.y = 32'd2;
    @(negedge clk);
    bus.x = 32'd77;   bus.y = 32'd10;
    sb.push_back(mk(32'd7, 32'd7, 1'b0));
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done("held");

    // Random signed operands against the language's own division semantics.
    for (int i = 0; i < 6; i++) begin
      int sx, sy;
      sx = $urandom;
      sy = (i < 3) ? int'($urandom_range(1, 1000)) : int'($urandom);
      if (i % 2 == 1) sy = -sy;
      if (sy == 0) sy = 1;
      if (sx == 32'h8000_0000 && sy == -1) sy = 3;
      start(sx, sy, 1'b1, mk(sx / sy, sx % sy, 1'b0));
      wait_done($sformatf("rand%0d", i));
    end

    // Asynchronous reset mid-division returns to reset values without a clock edge.
    start(32'd123, 32'd4, 1'b0, none);
    repeat (14) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_q", bus.q, 32'd0);
    check("arst_r", bus.r, 32'd0);
    check("arst_dz", {31'd0, bus.div_zero}, 32'd0);
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start(32'd7, 32'd7, 1'b1, mk(32'd1, 32'd0, 1'b0));
    wait_done("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
